x2_lane_pipe: RTL and testbench



---
 rtl/x2_lane_pipe.sv | 127 ++++++++++++
 tb/tb_x2_lane_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x2_lane_pipe.sv
// ----------------------------------------------------------------------------
// x2_lane_pipe
//
// Evaluates the 10-in/7-out x2 logic function on CHANNELS independent lanes
// per transaction. Results travel through an elastic pipeline of PIPE_STAGES
// register slices with full back-pressure. A saturating counter tracks how
// many results have been handed to the consumer.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input stream handshake
//   in_data             : lane k at [10k+9:10k], bit0=a ... bit9=j
//   out_valid/out_ready : output stream handshake
//   out_data            : lane k at [7k+6:7k], bit0=k ... bit6=q
//   cnt_clr             : synchronous clear of xfer_cnt (wins over an increment)
//   xfer_cnt            : saturating count of output handshakes
//
// Handshake semantics (both ports): a word moves on a rising clk edge where
// valid and ready are both 1. The producer may drop valid at any time; this
// block never waits on in_valid. Once out_valid is 1, it and out_data stay
// unchanged until the consumer accepts with out_ready.
// ----------------------------------------------------------------------------
module x2_lane_pipe #(
    parameter int CHANNELS    = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHANNELS*10-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHANNELS*7-1:0] out_data,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      xfer_cnt
);

    localparam int OW = CHANNELS * 7;

    // Single-lane x2 function: 10 inputs a..j, 7 outputs k..q.
    function automatic logic [6:0] x2_eval(input logic [9:0] x);
        logic a, b, c, d, e, f, g, h, i, j;
        logic [6:0] r;
        {j, i, h, g, f, e, d, c, b, a} = x;
        r[0] = ~(h & i & ~j);
        r[1] = (h ^ j) | i;
        r[2] = ~h & ~i & ~j;
        r[3] = ~(~a & ~b & ~c & i & ~h & ~j);
        r[4] = ~(g & h & ~(i & j));
        r[5] = ~g | (f & i & j & ~h) | (~i & ~j) | (d & ~e & h & ~j)
             | (~a & ~b & c & ((~h & ~i) | (h & i & j)));
        r[6] = ~g | (~i & ~(h ^ j)) | (f & i & j & ~h) | (d & e & h & i & ~j)
             | (~a & ~b & ~c & h & j);
        return r;
    endfunction

    logic [OW-1:0] f_data;

    always_comb begin
        f_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            f_data[7*c +: 7] = x2_eval(in_data[10*c +: 10]);
        end
    end

    logic [PIPE_STAGES-1:0] v;
    logic [PIPE_STAGES-1:0] rdy;
    logic [OW-1:0]          data [PIPE_STAGES];

    // A slice can load when it is empty or the slice after it is moving.
    // Walking from the output back keeps the chain free of bubbles; a local
    // accumulator avoids a self-referencing vector.
    always_comb begin : ready_chain
        logic down;
        rdy  = '0;
        down = out_ready;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            down   = ~v[s] | down;
            rdy[s] = down;
        end
    end

    assign in_ready = rdy[0];

    // Data only updates when a valid word arrives, so an empty slice keeps its
    // last contents and a full, stalled slice never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data[s] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= f_data;
                end
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (rdy[s]) begin
                    v[s] <= v[s-1];
                    if (v[s-1]) begin
                        data[s] <= data[s-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[PIPE_STAGES-1];
    assign out_data  = data[PIPE_STAGES-1];

    // Clear outranks the increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (cnt_clr) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_x2_lane_pipe.sv
// ----------------------------------------------------------------------------
// tb_x2_lane_pipe
//
// Two instances share clk/rst_n: a 4-lane, 2-stage, 8-bit-counter block that
// carries the scoreboard, and a 1-lane, 2-stage, 4-bit-counter block used for
// single-lane known values and counter saturation.
// ----------------------------------------------------------------------------
module tb_x2_lane_pipe;

    localparam int CH   = 4;
    localparam int PS   = 2;
    localparam int CW   = 8;
    localparam int DW   = CH * 10;
    localparam int OW   = CH * 7;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance
    logic          in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_data;
    logic [CW-1:0] xfer_cnt;

    // single-lane instance
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
    logic [9:0] s_in_data;
    logic [6:0] s_out_data;
    logic [3:0] s_xfer_cnt;

    x2_lane_pipe #(.CHANNELS(CH), .PIPE_STAGES(PS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
    );

    x2_lane_pipe #(.CHANNELS(1), .PIPE_STAGES(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .cnt_clr(s_cnt_clr), .xfer_cnt(s_xfer_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] x2_ref(input logic [9:0] w);
        logic a, b, c, d, e, f, g, h, i, j;
        logic k, l, m, n, o, p, q;
        {j, i, h, g, f, e, d, c, b, a} = w;
        k = !(h && i && !j);
        l = (h != j) || i;
        m = !h && !i && !j;
        n = !(!a && !b && !c && i && !h && !j);
        o = !(g && h && !(i && j));
        p = !g || (f && i && j && !h) || (!i && !j) || (d && !e && h && !j)
            || (!a && !b && c && ((!h && !i) || (h && i && j)));
        q = !g || (!i && (h == j)) || (f && i && j && !h) || (d && e && h && i && !j)
            || (!a && !b && !c && h && j);
        return {q, p, o, n, m, l, k};
    endfunction

    function automatic logic [OW-1:0] ref_word(input logic [DW-1:0] w);
        logic [OW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[7*c +: 7] = x2_ref(w[10*c +: 10]);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int            m_cnt;
    logic          hold_pending;
    logic [OW-1:0] held_data;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs are set by the caller just after a falling edge. Let them settle,
    // check the main instance against the model, predict the coming rising
    // edge, then move to just after the next falling edge.
    task automatic tick();
        logic [OW-1:0] e;
        logic          out_hs;
        #1;
        check("in_ready", in_ready, ((exp_q.size() < PS) || out_ready) ? 1 : 0);
        check("xfer_cnt", xfer_cnt, m_cnt);
        if (hold_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held_data);
        end
        if (out_valid && exp_q.size() == 0) check("spurious_out", out_valid, 0);
        out_hs = out_valid && out_ready;
        if (out_hs && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
        end
        hold_pending = out_valid && !out_ready;
        held_data    = out_data;
        if (in_valid && in_ready) exp_q.push_back(ref_word(in_data));
        if (cnt_clr) m_cnt = 0;
        else if (out_hs && m_cnt < CMAX) m_cnt++;
        @(negedge clk);
        #1;
    endtask

    // ---------------- known single-lane vectors ----------------
    typedef struct {
        logic [9:0] din;
        logic [6:0] dout;
    } vec_t;
    vec_t tbl[6];

    logic [OW-1:0] pack_exp;
    logic [DW-1:0] pack_in;

    initial begin
        tbl[0] = '{10'h000, 7'h7D};
        tbl[1] = '{10'h1D8, 7'h4A};
        tbl[2] = '{10'h3FF, 7'h1B};
        tbl[3] = '{10'h100, 7'h73};
        tbl[4] = '{10'h0C0, 7'h2B};
        tbl[5] = '{10'h2C4, 7'h49};

        rst_n = 1'b0;
        in_valid = 0; in_data = '0; out_ready = 0; cnt_clr = 0;
        s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_cnt_clr = 0;
        m_cnt = 0; hold_pending = 0; held_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_s_out_valid", s_out_valid, 0);
        check("rst_s_xfer_cnt", s_xfer_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_s_in_ready", s_in_ready, 1);

        // single-lane table with exact 2-cycle latency
        for (int t = 0; t < 6; t++) begin
            s_in_valid = 1; s_in_data = tbl[t].din; s_out_ready = 1;
            tick();
            s_in_valid = 0; s_in_data = $urandom_range(0, 1023);
            check("s_lat_early", s_out_valid, 0);
            tick();
            check("s_lat_valid", s_out_valid, 1);
            check("s_tbl_data", s_out_data, tbl[t].dout);
            tick();
            check("s_drained", s_out_valid, 0);
        end
        s_out_ready = 0;

        // multi-lane packing
        pack_in  = {10'h1D8, 10'h000, 10'h1D8, 10'h000};
        pack_exp = {7'h4A, 7'h7D, 7'h4A, 7'h7D};
        in_valid = 1; in_data = pack_in; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
        check("pack_valid", out_valid, 1);
        check("pack_data", out_data, pack_exp);
        tick();

        // streaming: 16 back-to-back words, counter cleared first
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        for (int i = 0; i < 19; i++) begin
            in_valid = (i < 16);
            in_data  = DW'({$urandom(), $urandom()});
            check("stream_valid", out_valid, (i >= 2 && i < 18) ? 1 : 0);
            tick();
        end
        check("stream_cnt", xfer_cnt, 16);

        // back-pressure
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = DW'({$urandom(), $urandom()});
            #1;
            check("bp_in_ready", in_ready, (i < 2) ? 1 : 0);
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (3) tick();
        check("bp_drained", exp_q.size(), 0);
        check("bp_out_valid", out_valid, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            in_data   = DW'({$urandom(), $urandom()});
            tick();
        end
        in_valid = 0; out_ready = 1; cnt_clr = 0;
        repeat (4) tick();
        check("rand_drained", exp_q.size(), 0);

        // reset with two words in flight
        out_ready = 0;
        in_valid = 1; in_data = DW'({$urandom(), $urandom()});
        tick();
        in_data = DW'({$urandom(), $urandom()});
        tick();
        in_valid = 0;
        check("mid_full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_xfer_cnt", xfer_cnt, 0);
        exp_q.delete();
        m_cnt = 0;
        hold_pending = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("mid_no_stale", out_valid, 0);
            tick();
        end

        // counter saturation on the 4-bit instance
        s_cnt_clr = 1;
        tick();
        s_cnt_clr = 0;
        s_out_ready = 1;
        for (int i = 0; i < 22; i++) begin
            s_in_valid = (i < 20);
            s_in_data  = $urandom_range(0, 1023);
            tick();
        end
        s_in_valid = 0;
        check("sat_cnt", s_xfer_cnt, 15);

        // clear coincident with a handshake
        s_cnt_clr = 1;
        tick();
        s_cnt_clr = 0;
        s_in_valid = 1; s_in_data = 10'h1D8;
        tick();
        s_in_valid = 0;
        tick();
        check("clr_hs_valid", s_out_valid, 1);
        check("clr_hs_data", s_out_data, 7'h4A);
        s_in_valid = 1; s_in_data = 10'h000;
        tick();
        s_in_valid = 0;
        tick();
        check("inc_cnt", s_xfer_cnt, 1);
        check("clr2_valid", s_out_valid, 1);
        s_cnt_clr = 1;
        tick();
        s_cnt_clr = 0;
        check("clr_wins", s_xfer_cnt, 0);
        check("clr_consumed", s_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
